mouse_packet_decoder: RTL and testbench

//   Upstream stage of the mouse IO bus peripheral (base 0xA0). Takes raw PS/2 bytes from the

---
 rtl/mouse_packet_decoder.sv | 198 +++++++++++++++++++
 tb/tb_mouse_packet_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mouse_packet_decoder.sv
// rtl/mouse_packet_decoder.sv - PS/2 stream packet assembler with clamped absolute X/Y tracking
// Define MOUSE_WHEEL_EN for 4-byte IntelliMouse packets with wheel accumulator.
module mouse_packet_decoder #(
  parameter int X_LIMIT        = 160,
  parameter int Y_LIMIT        = 120,
  parameter int X_INIT         = 80,
  parameter int Y_INIT         = 60,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       BYTE_ERROR,
  input  logic       STREAM_EN,
  output logic [3:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [7:0] MOUSE_Z,
  output logic       SEND_INTERRUPT
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [9:0] X_MAX = 10'(X_LIMIT - 1);
  localparam logic signed [9:0] Y_MAX = 10'(Y_LIMIT - 1);

  typedef enum logic [2:0] {S_B0, S_B1, S_B2, S_B3, S_UPD} state_t;

  state_t state, next_state;
  logic [TCW-1:0] tcnt;
  logic timeout;
  logic good_byte;
  logic in_pkt;
  logic cap0, cap1, cap2, cap3;
  logic upd;
  logic [7:0] b0_q, b1_q, b2_q;
  logic signed [9:0] dx, dy, xs, ys;
  logic [7:0] x_new, y_new;
  logic [7:0] x_res, y_res;
  logic [3:0] status_res;
  logic pend;

  assign good_byte = BYTE_VALID && !BYTE_ERROR;
  assign timeout   = (tcnt == T_LAST);

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_B0;
    else       state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    if (!STREAM_EN) begin
      next_state = S_B0;
    end else begin
      case (state)
        S_B0: if (good_byte && BYTE_IN[3]) next_state = S_B1;
        S_B1: begin
          if (BYTE_ERROR)      next_state = S_B0;
          else if (BYTE_VALID) next_state = S_B2;
          else if (timeout)    next_state = S_B0;
        end
        S_B2: begin
          if (BYTE_ERROR) next_state = S_B0;
`ifdef MOUSE_WHEEL_EN
          else if (BYTE_VALID) next_state = S_B3;
`else
          else if (BYTE_VALID) next_state = S_UPD;
`endif
          else if (timeout) next_state = S_B0;
        end
`ifdef MOUSE_WHEEL_EN
        S_B3: begin
          if (BYTE_ERROR)      next_state = S_B0;
          else if (BYTE_VALID) next_state = S_UPD;
          else if (timeout)    next_state = S_B0;
        end
`endif
        S_UPD:   next_state = S_B0;
        default: next_state = S_B0;
      endcase
    end
  end

  // output decode: byte capture strobes and update strobe
  always_comb begin
    cap0   = 1'b0;
    cap1   = 1'b0;
    cap2   = 1'b0;
    cap3   = 1'b0;
    upd    = 1'b0;
    in_pkt = 1'b0;
    if (STREAM_EN) begin
      case (state)
        S_B0:  cap0 = good_byte && BYTE_IN[3];
        S_B1:  begin cap1 = good_byte; in_pkt = 1'b1; end
        S_B2:  begin cap2 = good_byte; in_pkt = 1'b1; end
        S_B3:  begin cap3 = good_byte; in_pkt = 1'b1; end
        S_UPD: upd = 1'b1;
        default: ;
      endcase
    end
  end

  // inter-byte timeout only runs while a packet is partially assembled
  always_ff @(posedge CLK) begin
    if (RESET || !in_pkt || cap1 || cap2 || cap3) tcnt <= '0;
    else                                          tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      b0_q <= 8'h00;
      b1_q <= 8'h00;
      b2_q <= 8'h00;
    end else begin
      if (cap0) b0_q <= BYTE_IN;
      if (cap1) b1_q <= BYTE_IN;
      if (cap2) b2_q <= BYTE_IN;
    end
  end

  always_comb begin
    if (b0_q[6]) dx = b0_q[4] ? -10'sd256 : 10'sd255;
    else         dx = {{2{b0_q[4]}}, b1_q};
    if (b0_q[7]) dy = b0_q[5] ? -10'sd256 : 10'sd255;
    else         dy = {{2{b0_q[5]}}, b2_q};
    // PS/2 Y grows upward, screen Y grows downward
    xs = $signed({2'b00, MOUSE_X}) + dx;
    ys = $signed({2'b00, MOUSE_Y}) - dy;
    if (xs < 10'sd0)      x_new = 8'h00;
    else if (xs > X_MAX)  x_new = X_MAX[7:0];
    else                  x_new = xs[7:0];
    if (ys < 10'sd0)      y_new = 8'h00;
    else if (ys > Y_MAX)  y_new = Y_MAX[7:0];
    else                  y_new = ys[7:0];
  end

  // results are staged one cycle so outputs and interrupt appear together two edges after the last byte
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_res      <= 8'(X_INIT);
      y_res      <= 8'(Y_INIT);
      status_res <= 4'h0;
      pend       <= 1'b0;
    end else begin
      pend <= upd;
      if (upd) begin
        x_res      <= x_new;
        y_res      <= y_new;
        status_res <= b0_q[3:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MOUSE_X        <= 8'(X_INIT);
      MOUSE_Y        <= 8'(Y_INIT);
      MOUSE_STATUS   <= 4'h0;
      SEND_INTERRUPT <= 1'b0;
    end else begin
      SEND_INTERRUPT <= pend;
      if (pend) begin
        MOUSE_X      <= x_res;
        MOUSE_Y      <= y_res;
        MOUSE_STATUS <= status_res;
      end
    end
  end

`ifdef MOUSE_WHEEL_EN
  logic [7:0] b3_q;
  logic [7:0] z_res;

  always_ff @(posedge CLK) begin
    if (RESET)     b3_q <= 8'h00;
    else if (cap3) b3_q <= BYTE_IN;
  end

  // wheel count wraps modulo 256
  always_ff @(posedge CLK) begin
    if (RESET) begin
      z_res   <= 8'h00;
      MOUSE_Z <= 8'h00;
    end else begin
      if (upd)  z_res   <= MOUSE_Z + {{4{b3_q[3]}}, b3_q[3:0]};
      if (pend) MOUSE_Z <= z_res;
    end
  end
`else
  assign MOUSE_Z = 8'h00;
`endif

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// tb/tb_mouse_packet_decoder.sv - directed bench for mouse_packet_decoder
// Honours MOUSE_WHEEL_EN the same way as the design.
module tb_mouse_packet_decoder;
  localparam int TO = 64;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] BYTE_IN = 8'h00;
  logic       BYTE_VALID = 1'b0;
  logic       BYTE_ERROR = 1'b0;
  logic       STREAM_EN = 1'b1;
  logic [3:0] MOUSE_STATUS;
  logic [7:0] MOUSE_X, MOUSE_Y, MOUSE_Z;
  logic       SEND_INTERRUPT;

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  int base;
  logic [7:0] last_b;

  mouse_packet_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_ERROR(BYTE_ERROR), .STREAM_EN(STREAM_EN), .MOUSE_STATUS(MOUSE_STATUS),
    .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_Z(MOUSE_Z),
    .SEND_INTERRUPT(SEND_INTERRUPT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (SEND_INTERRUPT === 1'b1) irq_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    idle(10);
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
`ifdef MOUSE_WHEEL_EN
    send(8'h00);
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    idle(2);
    RESET = 1'b0;
    idle(1);
  endtask

  initial begin
    idle(3);
    RESET = 1'b0;
    idle(1);
    check("reset_x", MOUSE_X, 80);
    check("reset_y", MOUSE_Y, 60);
    check("reset_status", MOUSE_STATUS, 0);
    check("reset_z", MOUSE_Z, 0);
    check("reset_irq", SEND_INTERRUPT, 0);

    // basic packet with exact latency on the final byte
    base = irq_cnt;
    send(8'h08); send(8'h05);
`ifdef MOUSE_WHEEL_EN
    send(8'h03); last_b = 8'h00;
`else
    last_b = 8'h03;
`endif
    @(negedge CLK); BYTE_IN = last_b; BYTE_VALID = 1'b1;
    @(negedge CLK); BYTE_VALID = 1'b0;
    check("lat_k_irq", SEND_INTERRUPT, 0);
    check("lat_k_x", MOUSE_X, 80);
    @(negedge CLK);
    check("lat_k1_irq", SEND_INTERRUPT, 0);
    check("lat_k1_x", MOUSE_X, 80);
    @(negedge CLK);
    check("lat_k2_irq", SEND_INTERRUPT, 1);
    check("t1_x", MOUSE_X, 85);
    check("t1_y", MOUSE_Y, 57);
    check("t1_status", MOUSE_STATUS, 8);
    @(negedge CLK);
    check("lat_k3_irq", SEND_INTERRUPT, 0);
    idle(10);
    check("t1_irq_count", irq_cnt - base, 1);

    // negative X clamps to 0
    do_reset();
    pkt(8'h18, 8'h80, 8'h00);
    check("t2_x", MOUSE_X, 0);
    check("t2_y", MOUSE_Y, 60);

    // overflow bits, high clamps
    do_reset();
    pkt(8'h48, 8'h00, 8'h00);
    check("t3_x", MOUSE_X, 159);
    check("t3_y0", MOUSE_Y, 60);
    pkt(8'h28, 8'h00, 8'h00);
    check("t3_y", MOUSE_Y, 119);
    check("t3_x_hold", MOUSE_X, 159);

    // resync on missing sync bit
    do_reset();
    base = irq_cnt;
    send(8'h00);
    pkt(8'h09, 8'h01, 8'h01);
    check("t4_irq_count", irq_cnt - base, 1);
    check("t4_x", MOUSE_X, 81);
    check("t4_y", MOUSE_Y, 59);
    check("t4_status", MOUSE_STATUS, 9);

    // receiver error discards partial packet
    do_reset();
    base = irq_cnt;
    send(8'h08);
    @(negedge CLK); BYTE_ERROR = 1'b1;
    @(negedge CLK); BYTE_ERROR = 1'b0;
    idle(5);
    pkt(8'h08, 8'h02, 8'h02);
    check("t5_irq_count", irq_cnt - base, 1);
    check("t5_x", MOUSE_X, 82);
    check("t5_y", MOUSE_Y, 58);

    // inter-byte timeout discards partial packet
    base = irq_cnt;
    send(8'h08);
    idle(TO + 5);
    pkt(8'h08, 8'h01, 8'h00);
    check("t5_to_irq_count", irq_cnt - base, 1);
    check("t5_to_x", MOUSE_X, 83);
    check("t5_to_y", MOUSE_Y, 58);

    // gap just under the timeout keeps the packet alive
    base = irq_cnt;
    send(8'h08);
    idle(TO - 20);
    send(8'h01); send(8'h00);
`ifdef MOUSE_WHEEL_EN
    send(8'h00);
`endif
    check("gap_ok_irq_count", irq_cnt - base, 1);
    check("gap_ok_x", MOUSE_X, 84);

    // valid and error together: error wins
    base = irq_cnt;
    send(8'h08);
    @(negedge CLK); BYTE_IN = 8'h05; BYTE_VALID = 1'b1; BYTE_ERROR = 1'b1;
    @(negedge CLK); BYTE_VALID = 1'b0; BYTE_ERROR = 1'b0;
    idle(5);
    pkt(8'h08, 8'h01, 8'h00);
    check("err_wins_irq_count", irq_cnt - base, 1);
    check("err_wins_x", MOUSE_X, 85);

    // stream disabled: bytes ignored, outputs hold
    base = irq_cnt;
    STREAM_EN = 1'b0;
    pkt(8'h08, 8'h05, 8'h03);
    check("stream_off_irq_count", irq_cnt - base, 0);
    check("stream_off_x", MOUSE_X, 85);
    STREAM_EN = 1'b1;

    // reset mid-packet
    send(8'h08); send(8'h05);
    do_reset();
    base = irq_cnt;
    pkt(8'h08, 8'h01, 8'h01);
    check("midrst_irq_count", irq_cnt - base, 1);
    check("midrst_x", MOUSE_X, 81);
    check("midrst_y", MOUSE_Y, 59);

    // wheel
    do_reset();
    base = irq_cnt;
`ifdef MOUSE_WHEEL_EN
    send(8'h08); send(8'h00); send(8'h00); send(8'h0F);
    check("t6_z_ff", MOUSE_Z, 8'hFF);
    send(8'h08); send(8'h00); send(8'h00); send(8'h02);
    check("t6_z_01", MOUSE_Z, 8'h01);
    check("t6_irq_count", irq_cnt - base, 2);
`else
    send(8'h08); send(8'h00); send(8'h00);
    check("t6_irq_count", irq_cnt - base, 1);
    check("t6_z", MOUSE_Z, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
